// File: rtl/fsb_arb_pkg.sv
// Shared constants and types for the FSB transmit arbiter.
package fsb_arb_pkg;
  localparam int FSB_WIDTH = 80;
  localparam int MAX_REQ   = 16;
  localparam int MAX_BURST = 256;

  typedef logic [$clog2(MAX_REQ)-1:0]     req_id_t;
  typedef logic [$clog2(MAX_BURST+1)-1:0] beat_cnt_t;
endpackage

// File: rtl/fsb_rr_pick.sv
// Rotating priority picker: first requester after `last_i`, wrapping around,
// with `last_i` itself searched last.
module fsb_rr_pick #(
  parameter int num_req_p = 4,
  parameter int id_w_p    = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] req_i,
  input  logic [id_w_p-1:0]    last_i,
  output logic [num_req_p-1:0] gnt_oh_o,
  output logic [id_w_p-1:0]    gnt_id_o,
  output logic                 found_o
);
  logic [id_w_p-1:0] idx;

  always_comb begin
    gnt_oh_o = '0;
    gnt_id_o = '0;
    found_o  = 1'b0;
    idx      = '0;
    for (int off = 1; off <= num_req_p; off++) begin
      idx = id_w_p'((int'(last_i) + off) % num_req_p);
      if (!found_o && req_i[idx]) begin
        found_o       = 1'b1;
        gnt_id_o      = idx;
        gnt_oh_o[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fsb_tx_rr_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one registered FSB master link.
module fsb_tx_rr_arbiter
  import fsb_arb_pkg::*;
#(
  parameter int fsb_width_p = FSB_WIDTH,
  parameter int num_req_p   = 4,
  parameter int burst_len_p = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*fsb_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]             req_r_o,
  output logic                             m_fsb_v_o,
  output logic [fsb_width_p-1:0]           m_fsb_data_o,
  input  logic                             m_fsb_r_i,
  output logic [$clog2(num_req_p)-1:0]     grant_id_o,
  output logic                             busy_o
);
  localparam int ID_W   = $clog2(num_req_p);
  localparam int BEAT_W = $clog2(burst_len_p+1);
  localparam logic [BEAT_W-1:0] BURST_MAX = BEAT_W'(burst_len_p);

  logic                   out_v_q, out_v_d;
  logic [fsb_width_p-1:0] data_q, data_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic                   owner_v_q, owner_v_d;
  logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;

  logic                   ld, hold, accept;
  logic [ID_W-1:0]        sel_id, rot_id;
  logic [num_req_p-1:0]   rot_oh;
  logic                   rot_found;
  logic [fsb_width_p-1:0] req_data_a [num_req_p];

  for (genvar i = 0; i < num_req_p; i++) begin : g_unpack
    assign req_data_a[i] = req_data_i[i*fsb_width_p +: fsb_width_p];
  end

  fsb_rr_pick #(.num_req_p(num_req_p), .id_w_p(ID_W)) u_pick (
    .req_i    (req_v_i),
    .last_i   (last_q),
    .gnt_oh_o (rot_oh),
    .gnt_id_o (rot_id),
    .found_o  (rot_found)
  );

  always_comb begin
    out_v_d    = out_v_q;
    data_d     = data_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    owner_v_d  = owner_v_q;
    beat_cnt_d = beat_cnt_q;
    req_r_o    = '0;

    ld     = ~out_v_q | m_fsb_r_i;
    hold   = owner_v_q & req_v_i[last_q] & (beat_cnt_q < BURST_MAX);
    sel_id = hold ? last_q : rot_id;
    // Reset gates acceptance so no requester sees a handshake it will lose.
    accept = reset_n_i & ld & (hold | rot_found);

    if (accept) begin
      req_r_o[sel_id] = 1'b1;
      out_v_d         = 1'b1;
      data_d          = req_data_a[sel_id];
      grant_id_d      = sel_id;
      last_d          = sel_id;
      owner_v_d       = 1'b1;
      beat_cnt_d      = hold ? beat_cnt_q + 1'b1 : BEAT_W'(1);
    end else if (ld) begin
      // An idle slot releases ownership; the next winner comes from rotation.
      out_v_d    = 1'b0;
      owner_v_d  = 1'b0;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      out_v_q    <= 1'b0;
      data_q     <= '0;
      grant_id_q <= '0;
      last_q     <= ID_W'(num_req_p-1);
      owner_v_q  <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      out_v_q    <= out_v_d;
      data_q     <= data_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      owner_v_q  <= owner_v_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign m_fsb_v_o    = out_v_q;
  assign m_fsb_data_o = data_q;
  assign grant_id_o   = grant_id_q;
  assign busy_o       = out_v_q;

`ifndef SYNTHESIS
  a_onehot_rdy : assert property (@(posedge clk_i) $onehot0(req_r_o));
  a_stable_data : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (m_fsb_v_o & ~m_fsb_r_i) |=> $stable(m_fsb_data_o));
`endif
endmodule

// File: tb/tb_fsb_tx_rr_arbiter.sv
// Bench for fsb_tx_rr_arbiter: burst=4 and burst=1 instances share stimulus,
// each checked against a transaction-level round-robin model.
module tb_fsb_tx_rr_arbiter;
  localparam int W = 80;
  localparam int N = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_v;
  logic [N*W-1:0] req_data;
  logic           m_r;

  logic [N-1:0]   r0, r1;
  logic           v0, v1, b0, b1;
  logic [W-1:0]   d0, d1;
  logic [IDW-1:0] g0, g1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance (0: burst 4, 1: burst 1)
  bit           mv   [2];
  logic [W-1:0] md   [2];
  int           mid  [2];
  int           mlast[2];
  int           mrun [2];

  always #5 clk = ~clk;

  fsb_tx_rr_arbiter #(.fsb_width_p(W), .num_req_p(N), .burst_len_p(4)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_data_i(req_data),
    .req_r_o(r0), .m_fsb_v_o(v0), .m_fsb_data_o(d0), .m_fsb_r_i(m_r),
    .grant_id_o(g0), .busy_o(b0));

  fsb_tx_rr_arbiter #(.fsb_width_p(W), .num_req_p(N), .burst_len_p(1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_data_i(req_data),
    .req_r_o(r1), .m_fsb_v_o(v1), .m_fsb_data_o(d1), .m_fsb_r_i(m_r),
    .grant_id_o(g1), .busy_o(b1));

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rnd_data();
    for (int i = 0; i < N; i++)
      req_data[i*W +: W] = W'({$urandom, $urandom, $urandom});
  endtask

  // Inputs are set after a negedge; settle, check, advance model, go to next negedge.
  task automatic cycle();
    int b, win, nxt;
    bit ld, held;
    logic [N-1:0] exp_r;
    #1;
    for (int d = 0; d < 2; d++) begin
      b = (d == 0) ? 4 : 1;
      win = -1;
      held = 1'b0;
      exp_r = '0;
      ld = !mv[d] || m_r;
      if (reset_n && ld && req_v != '0) begin
        if (mrun[d] > 0 && req_v[mlast[d]] && mrun[d] < b) begin
          win = mlast[d];
          held = 1'b1;
        end else begin
          for (int j = 1; j <= N; j++) begin
            nxt = (mlast[d] + j) % N;
            if (win < 0 && req_v[nxt]) win = nxt;
          end
        end
        exp_r[win] = 1'b1;
      end
      chk($sformatf("req_r_d%0d", d), W'(d == 0 ? r0 : r1), W'(exp_r));
      chk($sformatf("m_v_d%0d", d),   W'(d == 0 ? v0 : v1), W'(mv[d]));
      chk($sformatf("busy_d%0d", d),  W'(d == 0 ? b0 : b1), W'(mv[d]));
      chk($sformatf("gid_d%0d", d),   W'(d == 0 ? g0 : g1), W'(mid[d]));
      if (mv[d]) chk($sformatf("data_d%0d", d), (d == 0 ? d0 : d1), md[d]);

      if (!reset_n) begin
        mv[d] = 1'b0; md[d] = '0; mid[d] = 0; mlast[d] = N-1; mrun[d] = 0;
      end else if (ld) begin
        if (win >= 0) begin
          mv[d] = 1'b1;
          md[d] = req_data[win*W +: W];
          mid[d] = win;
          mlast[d] = win;
          mrun[d] = held ? mrun[d] + 1 : 1;
        end else begin
          mv[d] = 1'b0;
          mrun[d] = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; req_v = '0; req_data = '0; m_r = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mv[d] = 1'b0; md[d] = 'x; mid[d] = 0; mlast[d] = N-1; mrun[d] = 0;
    end
    @(negedge clk);
    // Reset state
    cycle(); cycle();
    reset_n = 1'b1;

    // All requesting, ready held: burst of 4 per owner, 0 first
    req_v = 4'b1111; m_r = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rnd_data();
      #1;
      chk("p_burst_gnt", W'(r0), W'(4'(1 << (k / 4))));
      cycle();
    end

    // Two requesters, pure round-robin on burst=1 instance
    req_v = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      rnd_data();
      #1;
      chk("p_alt_onehot", W'($countones(r1)), W'(1));
      cycle();
    end

    // Stall: packet 80'h1234 held while ready low, then no-bubble reload
    req_v = 4'b0001; req_data[0 +: W] = 80'h1234;
    cycle();
    m_r = 1'b0; req_v = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rnd_data();
      cycle();
    end
    m_r = 1'b1; req_v = 4'b0010;
    cycle(); cycle();

    // Gap, then owner 2 drops after 2 beats while others wait
    req_v = 4'b0000; cycle();
    req_v = 4'b0100; rnd_data(); cycle(); cycle();
    req_v = 4'b0001; rnd_data(); cycle(); cycle();
    req_v = 4'b0000; cycle();
    req_v = 4'b0100; rnd_data(); cycle(); cycle();
    req_v = 4'b1001; rnd_data(); cycle(); cycle();

    // Single requester 3 for 10 packets
    req_v = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      rnd_data();
      #1;
      chk("p_single_rdy", W'(r0), W'(4'b1000));
      cycle();
    end

    // Reset while a packet is stalled in the output register
    req_v = 4'b0100; rnd_data(); cycle();
    m_r = 1'b0; req_v = 4'b1111; cycle();
    reset_n = 1'b0; cycle();
    reset_n = 1'b1; m_r = 1'b1; rnd_data();
    #1;
    chk("p_post_rst_gnt", W'(r0), W'(4'b0001));
    cycle(); cycle();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      req_v = N'($urandom);
      m_r = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
      rnd_data();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
